// File: rtl/rr_merge_arbiter.sv
// N-input round-robin merge onto one registered valid/ready output channel,
// with optional packet lock that holds the grant until the winner's last beat.
module rr_merge_arbiter #(
    parameter int N       = 4,
    parameter int WIDTH   = 33,
    parameter bit LOCK_EN = 1'b0,
    parameter int SELW    = ($clog2(N) > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       req_valid,
    input  logic [N*WIDTH-1:0] req_data,
    input  logic [N-1:0]       req_last,
    output logic [N-1:0]       req_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_sel,
    output logic               out_last,
    input  logic               out_ready
);

    typedef enum logic {
        UNLOCKED,
        LOCKED
    } lock_state_t;

    lock_state_t       lock_state;
    logic [SELW-1:0]   lock_idx;
    logic [SELW-1:0]   ptr;
    logic [SELW-1:0]   win;
    logic [SELW-1:0]   win_next;
    logic [SELW:0]     idx;
    logic [N-1:0]      elig;
    logic              found;
    logic              acc;

    always_comb begin
        acc = !rst && (!out_valid || out_ready);

        // While locked only the lock owner may compete, even when it is idle.
        elig = req_valid;
        if (lock_state == LOCKED) begin
            elig           = '0;
            elig[lock_idx] = req_valid[lock_idx];
        end

        // Search ptr, ptr+1, ... with an explicit wrap so non-power-of-two N works.
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (SELW+1)'(ptr) + (SELW+1)'(k);
            if (idx >= (SELW+1)'(N))
                idx = idx - (SELW+1)'(N);
            if (!found && elig[idx[SELW-1:0]]) begin
                found = 1'b1;
                win   = idx[SELW-1:0];
            end
        end

        win_next = (win == SELW'(N-1)) ? '0 : win + 1'b1;

        req_ready = '0;
        if (acc && found)
            req_ready[win] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_sel    <= '0;
            out_last   <= 1'b0;
            ptr        <= '0;
            lock_idx   <= '0;
            lock_state <= UNLOCKED;
        end else if (acc) begin
            if (found) begin
                out_valid <= 1'b1;
                out_data  <= req_data[win*WIDTH +: WIDTH];
                out_sel   <= win;
                out_last  <= req_last[win];
                if (LOCK_EN && !req_last[win]) begin
                    lock_state <= LOCKED;
                    lock_idx   <= win;
                end else begin
                    lock_state <= UNLOCKED;
                    ptr        <= win_next;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_merge_arbiter.sv
// Directed bench: a 4-input locking arbiter and a 3-input non-locking arbiter
// driven with hand-computed vectors.
module tb_rr_merge_arbiter;

    logic         clk;
    logic         rst;

    logic [3:0]   a_valid;
    logic [131:0] a_data;
    logic [3:0]   a_last;
    logic [3:0]   a_ready;
    logic         a_ovalid;
    logic [32:0]  a_odata;
    logic [1:0]   a_osel;
    logic         a_olast;
    logic         a_oready;

    logic [2:0]   b_valid;
    logic [23:0]  b_data;
    logic [2:0]   b_last;
    logic [2:0]   b_ready;
    logic         b_ovalid;
    logic [7:0]   b_odata;
    logic [1:0]   b_osel;
    logic         b_olast;
    logic         b_oready;

    int errors = 0;
    int checks = 0;

    rr_merge_arbiter #(.N(4), .WIDTH(33), .LOCK_EN(1'b1)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_valid), .req_data(a_data), .req_last(a_last), .req_ready(a_ready),
        .out_valid(a_ovalid), .out_data(a_odata), .out_sel(a_osel), .out_last(a_olast),
        .out_ready(a_oready)
    );

    rr_merge_arbiter #(.N(3), .WIDTH(8), .LOCK_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_valid), .req_data(b_data), .req_last(b_last), .req_ready(b_ready),
        .out_valid(b_ovalid), .out_data(b_odata), .out_sel(b_osel), .out_last(b_olast),
        .out_ready(b_oready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_a(input int i, input logic v, input logic [32:0] d, input logic l);
        a_valid[i]         = v;
        a_data[i*33 +: 33] = d;
        a_last[i]          = l;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        a_oready = 1'b1;
        b_oready = 1'b1;
        for (int i = 0; i < 4; i++) set_a(i, 1'b1, 33'h1_0000_0000 + 33'(i), 1'b1);
        b_valid = 3'b111;
        b_data = 24'h12_11_10;
        b_last = 3'b000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (a_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", a_ready); end
        checks++; if (b_ready !== 3'b000) begin errors++; $display("FAIL reset_ready_b: got %b expected 000", b_ready); end
        checks++; if (a_ovalid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", a_ovalid); end
        checks++; if (a_osel !== 2'd0) begin errors++; $display("FAIL reset_out_sel: got %0d expected 0", a_osel); end
        checks++; if (a_odata !== 33'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", a_odata); end
        rst = 1'b0;
        b_valid = 3'b000;
        #1;
        checks++; if (a_ready !== 4'b0001) begin errors++; $display("FAIL first_grant_ready: got %b expected 0001", a_ready); end
        @(negedge clk);
        checks++; if (a_ovalid !== 1'b1 || a_osel !== 2'd0) begin errors++; $display("FAIL first_grant_out: got v=%b sel=%0d expected v=1 sel=0", a_ovalid, a_osel); end
        checks++; if (a_odata !== 33'h1_0000_0000) begin errors++; $display("FAIL first_grant_data: got %h expected 100000000", a_odata); end
        a_valid = 4'b0000;
    endtask

    task automatic test_single_request;
        set_a(2, 1'b1, 33'h0_0000_00A5, 1'b1);
        #1;
        checks++; if (a_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b expected 0100", a_ready); end
        @(negedge clk);
        set_a(2, 1'b0, 33'h0, 1'b1);
        checks++; if (a_ovalid !== 1'b1 || a_osel !== 2'd2) begin errors++; $display("FAIL single_out: got v=%b sel=%0d expected v=1 sel=2", a_ovalid, a_osel); end
        checks++; if (a_odata !== 33'h0_0000_00A5) begin errors++; $display("FAIL single_data: got %h expected 0a5", a_odata); end
        @(negedge clk);
        checks++; if (a_ovalid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b expected 0", a_ovalid); end
        checks++; if (a_osel !== 2'd2 || a_odata !== 33'h0_0000_00A5) begin errors++; $display("FAIL drain_hold: got sel=%0d data=%h expected sel=2 data=0a5", a_osel, a_odata); end
    endtask

    task automatic test_fairness;
        logic [7:0] exp_data;
        b_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            exp_data = 8'h10 + 8'(k % 3);
            #1;
            checks++; if (b_ready !== 3'(1 << (k % 3))) begin errors++; $display("FAIL fair_ready[%0d]: got %b expected %b", k, b_ready, 3'(1 << (k % 3))); end
            @(negedge clk);
            checks++; if (b_ovalid !== 1'b1 || b_osel !== 2'(k % 3)) begin errors++; $display("FAIL fair_sel[%0d]: got v=%b sel=%0d expected v=1 sel=%0d", k, b_ovalid, b_osel, k % 3); end
            checks++; if (b_odata !== exp_data || b_olast !== 1'b0) begin errors++; $display("FAIL fair_data[%0d]: got %h last=%b expected %h last=0", k, b_odata, b_olast, exp_data); end
        end
        b_valid = 3'b000;
    endtask

    task automatic test_backpressure;
        set_a(0, 1'b1, 33'h0_0000_0D00, 1'b1);
        set_a(1, 1'b1, 33'h0_0000_0D01, 1'b1);
        #1;
        checks++; if (a_ready !== 4'b0001) begin errors++; $display("FAIL bp_first_ready: got %b expected 0001", a_ready); end
        @(negedge clk);
        checks++; if (a_osel !== 2'd0 || a_odata !== 33'h0_0000_0D00) begin errors++; $display("FAIL bp_first_out: got sel=%0d data=%h expected sel=0 data=d00", a_osel, a_odata); end
        a_oready = 1'b0;
        set_a(0, 1'b1, 33'h0_0000_0D0B, 1'b1);
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (a_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d]: got %b expected 0000", k, a_ready); end
            @(negedge clk);
            checks++; if (a_ovalid !== 1'b1 || a_osel !== 2'd0 || a_odata !== 33'h0_0000_0D00) begin errors++; $display("FAIL bp_hold[%0d]: got v=%b sel=%0d data=%h expected v=1 sel=0 data=d00", k, a_ovalid, a_osel, a_odata); end
        end
        a_oready = 1'b1;
        #1;
        checks++; if (a_ready !== 4'b0010) begin errors++; $display("FAIL bp_release_ready: got %b expected 0010", a_ready); end
        @(negedge clk);
        checks++; if (a_ovalid !== 1'b1 || a_osel !== 2'd1 || a_odata !== 33'h0_0000_0D01) begin errors++; $display("FAIL bp_release_out: got v=%b sel=%0d data=%h expected v=1 sel=1 data=d01", a_ovalid, a_osel, a_odata); end
        a_valid[1] = 1'b0;
        #1;
        checks++; if (a_ready !== 4'b0001) begin errors++; $display("FAIL bp_resume_ready: got %b expected 0001", a_ready); end
        @(negedge clk);
        checks++; if (a_ovalid !== 1'b1 || a_osel !== 2'd0 || a_odata !== 33'h0_0000_0D0B) begin errors++; $display("FAIL bp_resume_out: got v=%b sel=%0d data=%h expected v=1 sel=0 data=d0b", a_ovalid, a_osel, a_odata); end
        a_valid = 4'b0000;
    endtask

    task automatic test_packet_lock;
        set_a(1, 1'b1, 33'h1_1111_0000, 1'b0);
        set_a(2, 1'b1, 33'h1_2222_0000, 1'b1);
        #1;
        checks++; if (a_ready !== 4'b0010) begin errors++; $display("FAIL lock_b0_ready: got %b expected 0010", a_ready); end
        @(negedge clk);
        checks++; if (a_osel !== 2'd1 || a_odata !== 33'h1_1111_0000 || a_olast !== 1'b0) begin errors++; $display("FAIL lock_b0_out: got sel=%0d data=%h last=%b expected sel=1 data=111110000 last=0", a_osel, a_odata, a_olast); end
        set_a(1, 1'b1, 33'h1_1111_0001, 1'b0);
        #1;
        checks++; if (a_ready !== 4'b0010) begin errors++; $display("FAIL lock_b1_ready: got %b expected 0010", a_ready); end
        @(negedge clk);
        checks++; if (a_osel !== 2'd1 || a_odata !== 33'h1_1111_0001) begin errors++; $display("FAIL lock_b1_out: got sel=%0d data=%h expected sel=1 data=111110001", a_osel, a_odata); end
        a_valid[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++; if (a_ready !== 4'b0000) begin errors++; $display("FAIL lock_gap_ready[%0d]: got %b expected 0000", k, a_ready); end
            @(negedge clk);
            checks++; if (a_ovalid !== 1'b0) begin errors++; $display("FAIL lock_gap_valid[%0d]: got %b expected 0", k, a_ovalid); end
        end
        set_a(1, 1'b1, 33'h1_1111_0002, 1'b1);
        #1;
        checks++; if (a_ready !== 4'b0010) begin errors++; $display("FAIL lock_b2_ready: got %b expected 0010", a_ready); end
        @(negedge clk);
        checks++; if (a_osel !== 2'd1 || a_odata !== 33'h1_1111_0002 || a_olast !== 1'b1) begin errors++; $display("FAIL lock_b2_out: got sel=%0d data=%h last=%b expected sel=1 data=111110002 last=1", a_osel, a_odata, a_olast); end
        a_valid[1] = 1'b0;
        #1;
        checks++; if (a_ready !== 4'b0100) begin errors++; $display("FAIL unlock_ready: got %b expected 0100", a_ready); end
        @(negedge clk);
        checks++; if (a_ovalid !== 1'b1 || a_osel !== 2'd2 || a_odata !== 33'h1_2222_0000) begin errors++; $display("FAIL unlock_out: got v=%b sel=%0d data=%h expected v=1 sel=2 data=122220000", a_ovalid, a_osel, a_odata); end
        a_valid = 4'b0000;
    endtask

    task automatic test_reset_mid_packet;
        set_a(1, 1'b1, 33'h0_7777_0000, 1'b0);
        set_a(2, 1'b1, 33'h0_5555_0000, 1'b1);
        #1;
        checks++; if (a_ready !== 4'b0010) begin errors++; $display("FAIL rmp_ready: got %b expected 0010", a_ready); end
        @(negedge clk);
        checks++; if (a_osel !== 2'd1 || a_odata !== 33'h0_7777_0000) begin errors++; $display("FAIL rmp_b0_out: got sel=%0d data=%h expected sel=1 data=077770000", a_osel, a_odata); end
        rst = 1'b1;
        a_oready = 1'b0;
        #1;
        checks++; if (a_ready !== 4'b0000) begin errors++; $display("FAIL rmp_rst_ready: got %b expected 0000", a_ready); end
        @(negedge clk);
        checks++; if (a_ovalid !== 1'b0 || a_osel !== 2'd0 || a_odata !== 33'h0 || a_olast !== 1'b0) begin errors++; $display("FAIL rmp_rst_out: got v=%b sel=%0d data=%h last=%b expected all 0", a_ovalid, a_osel, a_odata, a_olast); end
        rst = 1'b0;
        a_oready = 1'b1;
        set_a(1, 1'b0, 33'h0_7777_0001, 1'b1);
        #1;
        checks++; if (a_ready !== 4'b0100) begin errors++; $display("FAIL rmp_unlocked_ready: got %b expected 0100", a_ready); end
        a_valid[1] = 1'b1;
        #1;
        checks++; if (a_ready !== 4'b0010) begin errors++; $display("FAIL rmp_ptr0_ready: got %b expected 0010", a_ready); end
        @(negedge clk);
        checks++; if (a_ovalid !== 1'b1 || a_osel !== 2'd1 || a_odata !== 33'h0_7777_0001) begin errors++; $display("FAIL rmp_post_out: got v=%b sel=%0d data=%h expected v=1 sel=1 data=077770001", a_ovalid, a_osel, a_odata); end
        a_valid[1] = 1'b0;
        #1;
        checks++; if (a_ready !== 4'b0100) begin errors++; $display("FAIL rmp_next_ready: got %b expected 0100", a_ready); end
        @(negedge clk);
        checks++; if (a_osel !== 2'd2 || a_odata !== 33'h0_5555_0000) begin errors++; $display("FAIL rmp_next_out: got sel=%0d data=%h expected sel=2 data=055550000", a_osel, a_odata); end
        a_valid = 4'b0000;
    endtask

    initial begin
        a_valid = '0;
        a_data = '0;
        a_last = '0;
        b_valid = '0;
        b_data = '0;
        b_last = '0;
        a_oready = 1'b1;
        b_oready = 1'b1;
        rst = 1'b1;
        test_reset();
        test_single_request();
        test_fairness();
        test_backpressure();
        test_packet_lock();
        test_reset_mid_packet();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule
